// File: rtl/commit_trace_mon.sv
// Commit-stream monitor: retire/recovery counters, commit-starvation watchdog,
// and a DEPTH-entry ring of the most recent retirements readable by debug logic.
module commit_trace_mon #(
    parameter int ROB_W       = 6,
    parameter int DEPTH       = 16,
    parameter int WDOG_CYCLES = 5000,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        commit_valid,
    input  logic                        commit_ready,
    input  logic                        recover_valid,
    input  logic [ROB_W-1:0]            commit_rob,
    input  logic [31:0]                 commit_pc,
    input  logic                        commit_uses_rd,
    input  logic [4:0]                  commit_rd,
    input  logic [31:0]                 commit_data,
    input  logic                        clear,
    input  logic                        freeze,
    input  logic [$clog2(DEPTH)-1:0]    rd_idx,
    output logic                        rd_valid,
    output logic [32+32+5+1+ROB_W-1:0]  rd_entry,
    output logic [$clog2(DEPTH):0]      fill,
    output logic [CNT_W-1:0]            commit_count,
    output logic [CNT_W-1:0]            recover_count,
    output logic [CNT_W-1:0]            idle_cycles,
    output logic                        hang,
    output logic [1:0]                  state
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + 32 + 5 + 1 + ROB_W;
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [AW:0]      FULL      = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HUNG   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic          acc;
    logic          capture;
    logic          rd_hit;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic [EW-1:0] new_entry;
    logic [EW-1:0] ring [DEPTH];

    assign acc       = commit_valid & commit_ready & ~recover_valid;
    assign capture   = acc & ((cur_state == IDLE) | (cur_state == RUN));
    assign new_entry = {commit_pc, commit_data & {32{commit_uses_rd}},
                        commit_rd, commit_uses_rd, commit_rob};
    // rd_idx 0 is the newest entry, i.e. the slot just behind wr_ptr
    assign rd_addr   = wr_ptr - AW'(1) - rd_idx;
    assign rd_hit    = ({1'b0, rd_idx} < fill);

    always_ff @(posedge clk) begin
        if (rst || clear) cur_state <= IDLE;
        else              cur_state <= nxt_state;
    end

    // Watchdog expiry takes priority over a simultaneous freeze request
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (acc) nxt_state = RUN;
            RUN: begin
                if (!acc && idle_cycles == WDOG_LAST) nxt_state = HUNG;
                else if (freeze)                      nxt_state = FROZEN;
            end
            FROZEN:  if (!freeze) nxt_state = RUN;
            HUNG:    nxt_state = HUNG;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        hang  = (cur_state == HUNG);
        state = cur_state;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr        <= '0;
            fill          <= '0;
            commit_count  <= '0;
            recover_count <= '0;
            idle_cycles   <= '0;
            rd_valid      <= 1'b0;
            rd_entry      <= '0;
        end else begin
            if (acc && commit_count != '1)
                commit_count <= commit_count + CNT_W'(1);
            if (recover_valid && recover_count != '1)
                recover_count <= recover_count + CNT_W'(1);
            if (acc)
                idle_cycles <= '0;
            else if ((cur_state == RUN || cur_state == FROZEN) && idle_cycles != '1)
                idle_cycles <= idle_cycles + CNT_W'(1);
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FULL) fill <= fill + (AW + 1)'(1);
            end
            rd_valid <= rd_hit;
            rd_entry <= rd_hit ? ring[rd_addr] : '0;
        end
    end

    // Ring storage is not reset; fill/rd_valid gate every stale slot
    always_ff @(posedge clk) begin
        if (capture && !rst && !clear) ring[wr_ptr] <= new_entry;
    end

endmodule
